// File: rtl/csa_accum_sequencer.sv
// Multi-cycle carry-save accumulator controller.
// Streams beats of TERMS_PER_CYCLE operands through one 3:2 compressor
// reduction with the registered carry/sum pair fed back each cycle, then
// presents the redundant (C, S) result on a valid/ready output.

// N-input to 2-output carry-save reduction built from a chain of 3:2 stages.
// Carries out of the MSB are dropped, so the result is exact mod 2^W.
module compressor_tree_3_to_2 #(
    parameter int W = 16,
    parameter int N = 6
) (
    input  logic [W-1:0] in_i [N],
    output logic [W-1:0] c_o,
    output logic [W-1:0] s_o
);

    logic [W-1:0] sumAcc;
    logic [W-1:0] carryAcc;

    function automatic logic [W-1:0] majShift(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [W-1:0] c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    // Fold each additional term into the running carry/sum pair.
    always_comb begin
        sumAcc   = in_i[0];
        carryAcc = in_i[1];
        for (int k = 2; k < N; k++) begin
            {carryAcc, sumAcc} = {majShift(sumAcc, carryAcc, in_i[k]),
                                  sumAcc ^ carryAcc ^ in_i[k]};
        end
    end

    assign c_o = carryAcc;
    assign s_o = sumAcc;

endmodule

module csa_accum_sequencer #(
    parameter  int BIT_LEN         = 16,
    parameter  int TERMS_PER_CYCLE = 4,
    parameter  int MAX_BEATS       = 255,
    localparam int CNT_W           = $clog2(MAX_BEATS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIT_LEN-1:0] in_terms [TERMS_PER_CYCLE],
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIT_LEN-1:0] out_C,
    output logic [BIT_LEN-1:0] out_S,
    output logic [CNT_W-1:0]   out_beats,
    output logic               out_overflow
);

    localparam int TREE_N = TERMS_PER_CYCLE + 2;

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_DONE  = 1'b1
    } state_e;

    state_e             state_q;
    logic [BIT_LEN-1:0] acc_c_q;
    logic [BIT_LEN-1:0] acc_s_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;

    logic [BIT_LEN-1:0] acc_c_d;
    logic [BIT_LEN-1:0] acc_s_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               cnt_at_max;
    logic               accept;
    logic [BIT_LEN-1:0] tree_in [TREE_N];

    // Tree operands: the fed-back carry/sum pair followed by this beat's terms.
    always_comb begin
        tree_in[0] = acc_c_q;
        tree_in[1] = acc_s_q;
        for (int k = 0; k < TERMS_PER_CYCLE; k++) begin
            tree_in[k + 2] = in_terms[k];
        end
    end

    compressor_tree_3_to_2 #(
        .W (BIT_LEN),
        .N (TREE_N)
    ) u_tree (
        .in_i (tree_in),
        .c_o  (acc_c_d),
        .s_o  (acc_s_d)
    );

    // Beats are only taken while accumulating and never during an abort.
    assign in_ready   = (state_q == S_ACCUM) && !clear;
    assign accept     = in_valid && in_ready;
    assign cnt_at_max = (cnt_q == CNT_W'(MAX_BEATS));
    assign cnt_d      = cnt_at_max ? cnt_q : cnt_q + 1'b1;

    // Sequencer: accumulate beats, hold the result until taken, abort on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACCUM;
            acc_c_q <= '0;
            acc_s_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            state_q <= S_ACCUM;
            acc_c_q <= '0;
            acc_s_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (accept) begin
                        acc_c_q <= acc_c_d;
                        acc_s_q <= acc_s_d;
                        cnt_q   <= cnt_d;
                        ovf_q   <= ovf_q | cnt_at_max;
                        if (in_last) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_ACCUM;
                        acc_c_q <= '0;
                        acc_s_q <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign out_valid    = (state_q == S_DONE);
    assign out_C        = acc_c_q;
    assign out_S        = acc_s_q;
    assign out_beats    = cnt_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Testbench for csa_accum_sequencer: directed vector table, hand-written
// backpressure and reset sequences, then random traffic against a
// running-sum reference model.

module tb_csa_accum_sequencer;

    localparam int BL  = 16;
    localparam int TPC = 4;
    localparam int MB  = 4;
    localparam int CW  = 3;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [BL-1:0] in_terms [TPC];
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [BL-1:0] out_C;
    logic [BL-1:0] out_S;
    logic [CW-1:0] out_beats;
    logic          out_overflow;

    int   total;
    int   bad;
    logic sampledReady;

    csa_accum_sequencer #(
        .BIT_LEN         (BL),
        .TERMS_PER_CYCLE (TPC),
        .MAX_BEATS       (MB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_terms     (in_terms),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_C        (out_C),
        .out_S        (out_S),
        .out_beats    (out_beats),
        .out_overflow (out_overflow)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic             last;
        logic             clr;
        logic             ordy;
        logic [3:0][15:0] t;
        logic             expRdy;
        logic             expOv;
        logic [15:0]      expSum;
        logic [2:0]       expBeats;
        logic             expOvf;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(input logic v, input logic last, input logic clr,
                                input logic ordy, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] c,
                                input logic [15:0] d, input logic rdy,
                                input logic ov, input logic [15:0] sum,
                                input logic [2:0] beats, input logic ovf);
        vec_t r;
        r.v = v; r.last = last; r.clr = clr; r.ordy = ordy;
        r.t[0] = a; r.t[1] = b; r.t[2] = c; r.t[3] = d;
        r.expRdy = rdy; r.expOv = ov; r.expSum = sum;
        r.expBeats = beats; r.expOvf = ovf;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, sample in_ready before the edge, and return
    // one time unit after the rising edge.
    task automatic applyStimulus(input logic v, input logic last, input logic clr,
                                 input logic ordy, input logic [3:0][15:0] t);
        in_valid  = v;
        in_last   = last;
        clear     = clr;
        out_ready = ordy;
        for (int i = 0; i < TPC; i++) in_terms[i] = t[i];
        #1;
        sampledReady = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResult(input string tag, input logic expOv,
                               input logic [15:0] expSum, input logic [2:0] expBeats,
                               input logic expOvf);
        logic [15:0] s;
        s = out_C + out_S;
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(expOv));
        if (expOv) begin
            checkOutput({tag, " sum"}, 32'(s), 32'(expSum));
            checkOutput({tag, " out_beats"}, 32'(out_beats), 32'(expBeats));
            checkOutput({tag, " out_overflow"}, 32'(out_overflow), 32'(expOvf));
        end
    endtask

    // Reference model: a plain running sum, beat count and pending flag.
    int unsigned mSum;
    int          mBeats;
    bit          mOvf;
    bit          mPending;

    task automatic modelReset();
        mSum = 0; mBeats = 0; mOvf = 0; mPending = 0;
    endtask

    initial begin
        logic [3:0][15:0] t;
        logic             v, last, clr, ordy;
        total = 0;
        bad   = 0;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < TPC; i++) in_terms[i] = '0;

        // Reset values appear without a clock edge.
        #2;
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst out_C", 32'(out_C), 32'd0);
        checkOutput("rst out_S", 32'(out_S), 32'd0);
        #10;
        rst_n = 1'b1;
        #1;
        checkOutput("post-rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("post-rst in_ready", 32'(in_ready), 32'd1);
        checkOutput("post-rst out_beats", 32'(out_beats), 32'd0);

        // Directed vectors: single beat, wrap, clear, saturation, clear in DONE.
        vecs[0]  = mk(1,1,0,1, 16'd1,16'd2,16'd3,16'd4,       1,1,16'd10,3'd1,0);
        vecs[1]  = mk(0,0,0,1, 0,0,0,0,                       0,0,0,0,0);
        vecs[2]  = mk(1,0,0,1, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF, 1,0,0,0,0);
        vecs[3]  = mk(1,0,0,1, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF, 1,0,0,0,0);
        vecs[4]  = mk(1,1,0,1, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF, 1,1,16'hFFF4,3'd3,0);
        vecs[5]  = mk(0,0,0,1, 0,0,0,0,                       0,0,0,0,0);
        vecs[6]  = mk(1,0,0,1, 16'd7,16'd7,16'd7,16'd7,       1,0,0,0,0);
        vecs[7]  = mk(1,0,0,1, 16'd7,16'd7,16'd7,16'd7,       1,0,0,0,0);
        vecs[8]  = mk(1,0,1,1, 16'd7,16'd7,16'd7,16'd7,       0,0,0,0,0);
        vecs[9]  = mk(1,1,0,1, 16'd1,16'd1,16'd1,16'd1,       1,1,16'd4,3'd1,0);
        vecs[10] = mk(0,0,0,1, 0,0,0,0,                       0,0,0,0,0);
        vecs[11] = mk(1,0,0,1, 16'd1,0,0,0,                   1,0,0,0,0);
        vecs[12] = mk(1,0,0,1, 16'd1,0,0,0,                   1,0,0,0,0);
        vecs[13] = mk(1,0,0,1, 16'd1,0,0,0,                   1,0,0,0,0);
        vecs[14] = mk(1,0,0,1, 16'd1,0,0,0,                   1,0,0,0,0);
        vecs[15] = mk(1,0,0,1, 16'd1,0,0,0,                   1,0,0,0,0);
        vecs[16] = mk(1,1,0,1, 16'd1,0,0,0,                   1,1,16'd6,3'd4,1);
        vecs[17] = mk(0,0,0,1, 0,0,0,0,                       0,0,0,0,0);
        vecs[18] = mk(1,1,0,1, 16'd2,0,0,0,                   1,1,16'd2,3'd1,0);
        vecs[19] = mk(0,0,0,1, 0,0,0,0,                       0,0,0,0,0);
        vecs[20] = mk(1,1,0,0, 16'd5,0,0,0,                   1,1,16'd5,3'd1,0);
        vecs[21] = mk(1,1,1,0, 16'd9,0,0,0,                   0,0,0,0,0);
        vecs[22] = mk(1,1,0,1, 16'd3,0,0,0,                   1,1,16'd3,3'd1,0);
        vecs[23] = mk(0,0,0,1, 0,0,0,0,                       0,0,0,0,0);

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].v, vecs[i].last, vecs[i].clr, vecs[i].ordy, vecs[i].t);
            checkOutput($sformatf("vec%0d in_ready", i), 32'(sampledReady), 32'(vecs[i].expRdy));
            checkResult($sformatf("vec%0d", i), vecs[i].expOv, vecs[i].expSum,
                        vecs[i].expBeats, vecs[i].expOvf);
        end

        // Backpressure: result held for five cycles while a beat waits.
        t = {16'd6, 16'd7, 16'd8, 16'd9};
        applyStimulus(1, 1, 0, 0, t);
        checkResult("bp load", 1, 16'd30, 3'd1, 0);
        t = {16'd1, 16'd1, 16'd1, 16'd1};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0, 0, t);
            checkOutput($sformatf("bp%0d in_ready", i), 32'(sampledReady), 32'd0);
            checkResult($sformatf("bp%0d", i), 1, 16'd30, 3'd1, 0);
        end
        applyStimulus(1, 1, 0, 1, t);
        checkOutput("bp release in_ready", 32'(sampledReady), 32'd0);
        checkResult("bp release", 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, t);
        checkOutput("bp next in_ready", 32'(sampledReady), 32'd1);
        checkResult("bp next", 1, 16'd4, 3'd1, 0);
        applyStimulus(0, 0, 0, 1, t);
        checkResult("bp drain", 0, 0, 0, 0);

        // Asynchronous reset in the middle of an operation.
        t = {16'd400, 16'd300, 16'd200, 16'd100};
        applyStimulus(1, 0, 0, 1, t);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst out_C", 32'(out_C), 32'd0);
        checkOutput("midrst out_S", 32'(out_S), 32'd0);
        checkOutput("midrst out_beats", 32'(out_beats), 32'd0);
        checkOutput("midrst in_ready", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        t = {16'd5, 16'd5, 16'd5, 16'd5};
        applyStimulus(1, 1, 0, 1, t);
        checkResult("after midrst", 1, 16'd20, 3'd1, 0);
        applyStimulus(0, 0, 0, 1, t);
        checkResult("after midrst drain", 0, 0, 0, 0);

        // Random traffic against the reference model.
        modelReset();
        for (int n = 0; n < 600; n++) begin
            v    = ($urandom_range(0, 3) != 0);
            last = ($urandom_range(0, 5) == 0);
            clr  = ($urandom_range(0, 19) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < TPC; i++) begin
                t[i] = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            end
            applyStimulus(v, last, clr, ordy, t);
            checkOutput($sformatf("rnd%0d in_ready", n), 32'(sampledReady),
                        32'(!mPending && !clr));
            if (clr) begin
                modelReset();
            end else if (!mPending) begin
                if (v) begin
                    for (int i = 0; i < TPC; i++) mSum += int'(t[i]);
                    if (mBeats == MB) mOvf = 1;
                    else mBeats++;
                    if (last) mPending = 1;
                end
            end else if (ordy) begin
                modelReset();
            end
            checkResult($sformatf("rnd%0d", n), mPending, 16'(mSum), 3'(mBeats), mOvf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_accum_sequencer.md
# csa_accum_sequencer

Multi-cycle carry-save accumulator controller. It streams an arbitrary number of beats of TERMS_PER_CYCLE operands through a single `compressor_tree_3_to_2` instance of TERMS_PER_CYCLE+2 inputs, feeding back its registered C/S pair every cycle. After the beat flagged last, it presents the redundant result (C, S) on a valid/ready output. It sits in front of the final carry-propagate adder in multiplier and reduction datapaths whose term count exceeds one tree's width.

## Interface
- BIT_LEN, 16, width of every term and of C/S
- TERMS_PER_CYCLE, 4, operands accepted per beat; must be ≥1
- MAX_BEATS, 255, beat-count saturation limit; CNT_W = $clog2(MAX_BEATS+1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort of the current operation
- in_valid  in  1  beat available
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_terms  in  BIT_LEN × TERMS_PER_CYCLE (unpacked array)  beat operands
- in_last  in  1  final beat of the operation
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- out_C  out  BIT_LEN  carry vector of the accumulated sum
- out_S  out  BIT_LEN  sum vector of the accumulated sum
- out_beats  out  CNT_W  beats accepted in this operation, saturating at MAX_BEATS
- out_overflow  out  1  beats accepted exceeded MAX_BEATS

## Operation
- Clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Two states, ACCUM and DONE. Reset state is ACCUM.
- Reset values: acc_C=0, acc_S=0, cnt=0, ovf=0, so in_ready=1 and out_valid=0.
- ACCUM:
  - in_ready = !clear.
  - On accept: {acc_C, acc_S} ← tree(acc_C, acc_S, in_terms[0..TERMS_PER_CYCLE-1]).
  - On accept: cnt ← min(cnt+1, MAX_BEATS); ovf ← ovf | (cnt == MAX_BEATS).
  - If in_last is set on the accepted beat, go to DONE.
- DONE:
  - in_ready=0, out_valid=1.
  - out_C=acc_C, out_S=acc_S, out_beats=cnt, out_overflow=ovf, all driven straight from registers.
  - On output handshake: acc_C, acc_S, cnt and ovf go to 0; go to ACCUM.
- Outputs are held stable while out_valid && !out_ready.
- clear has priority over everything except reset. In either state, the next cycle has acc_C/acc_S/cnt/ovf = 0 and the state is ACCUM.
  - A beat presented during clear is not accepted.
  - A pending result is discarded.
- Arithmetic is mod 2^BIT_LEN: (out_C + out_S) mod 2^BIT_LEN = Σ of all accepted terms mod 2^BIT_LEN. Tree carry-out MSBs are dropped.
- A zero-beat operation is impossible, because entry to DONE requires an accepted in_last beat.
- Reset asserted mid-operation: all state returns to reset values immediately; partial sums are lost.

## Timing
- One beat per cycle sustained in ACCUM. The combinational tree sits between the acc registers.
- Latency: out_valid rises the cycle after the in_last beat is accepted.
- Minimum one bubble per operation: in_ready=0 for every cycle spent in DONE, at least one.
- Earliest next-operation beat: the cycle after the output handshake.
- in_ready depends combinationally only on state and clear. out_valid is purely registered.

## Test plan
- Reset: hold rst_n=0, then release -> out_valid=0, in_ready=1, out_C=out_S=0 with no clock edge needed.
- Single beat: in_terms={1,2,3,4}, in_last=1, out_ready=1 -> next cycle out_valid=1, out_C+out_S=10, out_beats=1, out_overflow=0. The following cycle in_ready=1.
- Wrap: 3 back-to-back beats, each {0xFFFF×4}, last on the third -> out_C+out_S mod 2^16=0xFFF4, out_beats=3.
- Backpressure: result pending with out_ready=0 for 5 cycles while in_valid=1 -> outputs stable and in_ready=0 throughout. The new beat is accepted the cycle after out_ready=1.
- Clear mid-operation:
  - 2 beats {7,7,7,7} without last, then clear=1 with in_valid=1 -> beat not accepted.
  - Then {1,1,1,1} last -> out_C+out_S=4, out_beats=1.
- Saturation: MAX_BEATS=4, 6 beats {1,0,0,0} with last on the sixth -> out_C+out_S=6, out_beats=4, out_overflow=1. The next operation starts with out_overflow=0.
